// File: rtl/alarm_delay_sequencer.sv
// -----------------------------------------------------------------------------
// alarm_delay_sequencer
//
// Arm/disarm controller for the entry burglar alarm. One shared down-counter
// times the exit delay, the entry delay and the siren duration. Inputs come
// from the RFID authorization path and the door/motion sensors.
//
// Ports:
//   clk          system clock, all logic on the rising edge
//   reset        synchronous, active-low reset
//   arm_req      one-cycle arm request from keypad/button
//   tag_valid    one-cycle pulse, authorized RFID tag read
//   tag_invalid  one-cycle pulse, unauthorized RFID tag read
//   door_open    level, 1 = door contact open
//   motion       level, 1 = motion sensor active
//   state        current state code (0 DISARMED .. 4 ALARM)
//   countdown    remaining cycles in the current timed state
//   siren        1 while in ALARM
//   armed_led    1 in EXIT_DELAY, ARMED and ENTRY_DELAY
//   arm_fault    one-cycle pulse, arm rejected because the door is open
//   fail_cnt     consecutive invalid-tag count, saturating at MAX_FAILS
// -----------------------------------------------------------------------------
module alarm_delay_sequencer #(
   parameter int EXIT_CYCLES  = 20,
   parameter int ENTRY_CYCLES = 20,
   parameter int ALARM_CYCLES = 40,
   parameter int MAX_FAILS    = 3,
   localparam int MAX_EE      = (EXIT_CYCLES > ENTRY_CYCLES) ? EXIT_CYCLES : ENTRY_CYCLES,
   localparam int MAX_T       = (MAX_EE > ALARM_CYCLES) ? MAX_EE : ALARM_CYCLES,
   localparam int TW          = $clog2(MAX_T) + 1,
   localparam int FW          = $clog2(MAX_FAILS) + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          arm_req,
   input  logic          tag_valid,
   input  logic          tag_invalid,
   input  logic          door_open,
   input  logic          motion,
   output logic [2:0]    state,
   output logic [TW-1:0] countdown,
   output logic          siren,
   output logic          armed_led,
   output logic          arm_fault,
   output logic [FW-1:0] fail_cnt
);

   typedef enum logic [2:0] {
      DISARMED    = 3'd0,
      EXIT_DELAY  = 3'd1,
      ARMED       = 3'd2,
      ENTRY_DELAY = 3'd3,
      ALARM       = 3'd4
   } state_t;

   localparam logic [TW-1:0] EXIT_LOAD  = TW'(EXIT_CYCLES - 1);
   localparam logic [TW-1:0] ENTRY_LOAD = TW'(ENTRY_CYCLES - 1);
   localparam logic [TW-1:0] ALARM_LOAD = TW'(ALARM_CYCLES - 1);
   localparam logic [FW-1:0] FAIL_MAX   = FW'(MAX_FAILS);

   state_t        state_q, state_d;
   logic [TW-1:0] count_q, count_d;
   logic [FW-1:0] fail_q, fail_d;
   logic          fault_d;
   logic [FW-1:0] fail_inc;
   logic          fail_hit;

   // Saturating increment of the invalid-tag counter. fail_hit flags an
   // invalid tag that brings the count to the limit, which forces the siren
   // from any armed-side state.
   always_comb begin
      fail_inc = (fail_q >= FAIL_MAX) ? FAIL_MAX : fail_q + FW'(1);
      fail_hit = tag_invalid && (fail_inc == FAIL_MAX);
   end

   // Next-state logic. A valid tag always disarms (outside DISARMED), ahead of
   // invalid tags, timer expiry and sensors. Next comes the fail-limit escape
   // to ALARM, then the per-state timer and sensor transitions.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      fail_d  = fail_q;
      fault_d = 1'b0;

      if (state_q == DISARMED) begin
         fail_d  = '0;
         count_d = '0;
         if (arm_req) begin
            if (door_open) begin
               fault_d = 1'b1;
            end else begin
               state_d = EXIT_DELAY;
               count_d = EXIT_LOAD;
            end
         end
      end else if (tag_valid) begin
         state_d = DISARMED;
         count_d = '0;
         fail_d  = '0;
      end else begin
         if (tag_invalid) begin
            fail_d = fail_inc;
         end
         if (fail_hit && state_q != ALARM) begin
            state_d = ALARM;
            count_d = ALARM_LOAD;
         end else begin
            case (state_q)
               EXIT_DELAY: begin
                  if (count_q == '0) begin
                     if (door_open) begin
                        state_d = ENTRY_DELAY;
                        count_d = ENTRY_LOAD;
                     end else begin
                        state_d = ARMED;
                        count_d = '0;
                     end
                  end else begin
                     count_d = count_q - TW'(1);
                  end
               end
               ARMED: begin
                  count_d = '0;
                  if (motion) begin
                     state_d = ALARM;
                     count_d = ALARM_LOAD;
                  end else if (door_open) begin
                     state_d = ENTRY_DELAY;
                     count_d = ENTRY_LOAD;
                  end
               end
               ENTRY_DELAY: begin
                  if (count_q == '0) begin
                     state_d = ALARM;
                     count_d = ALARM_LOAD;
                  end else begin
                     count_d = count_q - TW'(1);
                  end
               end
               ALARM: begin
                  if (count_q == '0) begin
                     state_d = ARMED;
                     count_d = '0;
                  end else begin
                     count_d = count_q - TW'(1);
                  end
               end
               default: begin
                  state_d = DISARMED;
                  count_d = '0;
                  fail_d  = '0;
               end
            endcase
         end
      end
   end

   // State, counters and indicator outputs. siren and armed_led are decoded
   // from the next state so they switch on the same edge as state.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= DISARMED;
         count_q   <= '0;
         fail_q    <= '0;
         arm_fault <= 1'b0;
         siren     <= 1'b0;
         armed_led <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         fail_q    <= fail_d;
         arm_fault <= fault_d;
         siren     <= (state_d == ALARM);
         armed_led <= (state_d == EXIT_DELAY) || (state_d == ARMED) ||
                      (state_d == ENTRY_DELAY);
      end
   end

   assign state     = state_q;
   assign countdown = count_q;
   assign fail_cnt  = fail_q;

endmodule

// File: tb/tb_alarm_delay_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alarm_delay_sequencer
//
// Directed bench for alarm_delay_sequencer with EXIT=4, ENTRY=3, ALARM=5,
// MAX_FAILS=2. Inputs change 1 ns after a rising edge; outputs are checked
// at the same point, after the edge that consumed the previous inputs.
// -----------------------------------------------------------------------------
module tb_alarm_delay_sequencer;

   logic       clk = 1'b0;
   logic       reset;
   logic       arm_req, tag_valid, tag_invalid, door_open, motion;
   logic [2:0] state;
   logic [3:0] countdown;
   logic       siren, armed_led, arm_fault;
   logic [1:0] fail_cnt;

   int checks   = 0;
   int failures = 0;

   alarm_delay_sequencer #(
      .EXIT_CYCLES  (4),
      .ENTRY_CYCLES (3),
      .ALARM_CYCLES (5),
      .MAX_FAILS    (2)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .arm_req     (arm_req),
      .tag_valid   (tag_valid),
      .tag_invalid (tag_invalid),
      .door_open   (door_open),
      .motion      (motion),
      .state       (state),
      .countdown   (countdown),
      .siren       (siren),
      .armed_led   (armed_led),
      .arm_fault   (arm_fault),
      .fail_cnt    (fail_cnt)
   );

   always #5 clk = ~clk;

   // One clock edge, then clear the one-cycle pulses.
   task automatic applyStimulus();
      @(posedge clk);
      #1;
      arm_req     = 1'b0;
      tag_valid   = 1'b0;
      tag_invalid = 1'b0;
   endtask

   task automatic checkOutput(input string tag, input int observed, input int expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   task automatic checkAll(input string tag, input int st, input int cnt,
                           input int sir, input int led, input int fc);
      checkOutput({tag, ".state"},     int'(state),     st);
      checkOutput({tag, ".countdown"}, int'(countdown), cnt);
      checkOutput({tag, ".siren"},     int'(siren),     sir);
      checkOutput({tag, ".armed_led"}, int'(armed_led), led);
      checkOutput({tag, ".fail_cnt"},  int'(fail_cnt),  fc);
   endtask

   // Arm with the door closed and run the exit delay out to ARMED.
   task automatic armToArmed(input string tag);
      arm_req = 1'b1;
      applyStimulus();
      checkAll({tag, "_exit3"}, 1, 3, 0, 1, 0);
      for (int i = 2; i >= 0; i--) begin
         applyStimulus();
         checkOutput({tag, "_exitcnt"}, int'(countdown), i);
      end
      applyStimulus();
      checkAll({tag, "_armed"}, 2, 0, 0, 1, 0);
   endtask

   initial begin
      reset = 1'b0; arm_req = 1'b0; tag_valid = 1'b0; tag_invalid = 1'b0;
      door_open = 1'b0; motion = 1'b0;
      #1;
      applyStimulus();
      checkAll("reset", 0, 0, 0, 0, 0);
      checkOutput("reset.arm_fault", int'(arm_fault), 0);
      reset = 1'b1;
      applyStimulus();
      checkAll("idle", 0, 0, 0, 0, 0);

      // Normal arm
      armToArmed("t1");

      // Disarm, then open-door arm attempt
      tag_valid = 1'b1;
      applyStimulus();
      checkAll("t2_disarm", 0, 0, 0, 0, 0);
      door_open = 1'b1; arm_req = 1'b1;
      applyStimulus();
      checkOutput("t2_fault", int'(arm_fault), 1);
      checkOutput("t2_state", int'(state), 0);
      applyStimulus();
      checkOutput("t2_fault_clr", int'(arm_fault), 0);
      checkOutput("t2_state2", int'(state), 0);
      door_open = 1'b0;

      // Invalid tags ignored while disarmed
      tag_invalid = 1'b1;
      applyStimulus();
      checkAll("dis_inv", 0, 0, 0, 0, 0);

      // Exit delay cancelled by a valid tag
      arm_req = 1'b1;
      applyStimulus();
      checkOutput("cancel_exit", int'(state), 1);
      tag_valid = 1'b1;
      applyStimulus();
      checkAll("cancel", 0, 0, 0, 0, 0);

      // Entry then disarm
      armToArmed("t3");
      door_open = 1'b1;
      applyStimulus();
      checkAll("t3_entry", 3, 2, 0, 1, 0);
      tag_valid = 1'b1;
      applyStimulus();
      checkAll("t3_disarm", 0, 0, 0, 0, 0);
      door_open = 1'b0;

      // Entry timeout, siren, auto re-arm, re-entry
      armToArmed("t4");
      door_open = 1'b1;
      applyStimulus();
      checkAll("t4_entry2", 3, 2, 0, 1, 0);
      applyStimulus();
      checkOutput("t4_entry1", int'(countdown), 1);
      applyStimulus();
      checkOutput("t4_entry0", int'(countdown), 0);
      applyStimulus();
      checkAll("t4_alarm", 4, 4, 1, 0, 0);
      for (int i = 3; i >= 0; i--) begin
         applyStimulus();
         checkOutput("t4_alarmcnt", int'(countdown), i);
      end
      checkOutput("t4_siren_hold", int'(siren), 1);
      applyStimulus();
      checkAll("t4_rearm", 2, 0, 0, 1, 0);
      applyStimulus();
      checkAll("t4_reentry", 3, 2, 0, 1, 0);
      door_open = 1'b0; tag_valid = 1'b1;
      applyStimulus();
      checkAll("t4_disarm", 0, 0, 0, 0, 0);

      // Invalid tags
      armToArmed("t5");
      tag_invalid = 1'b1;
      applyStimulus();
      checkAll("t5_inv1", 2, 0, 0, 1, 1);
      tag_invalid = 1'b1;
      applyStimulus();
      checkAll("t5_inv2", 4, 4, 1, 0, 2);
      tag_invalid = 1'b1;
      applyStimulus();
      checkAll("t5_inv3", 4, 3, 1, 0, 2);
      tag_valid = 1'b1; tag_invalid = 1'b1;
      applyStimulus();
      checkAll("t5_both", 0, 0, 0, 0, 0);

      // Exit expiry with door open goes to entry; motion ignored in exit
      arm_req = 1'b1;
      applyStimulus();
      door_open = 1'b1; motion = 1'b1;
      applyStimulus();
      applyStimulus();
      applyStimulus();
      checkAll("exit_motion", 1, 0, 0, 1, 0);
      motion = 1'b0;
      applyStimulus();
      checkAll("exit_to_entry", 3, 2, 0, 1, 0);
      door_open = 1'b0; tag_valid = 1'b1;
      applyStimulus();
      checkOutput("exit_entry_disarm", int'(state), 0);

      // Priority and reset
      armToArmed("t6");
      motion = 1'b1; door_open = 1'b1;
      applyStimulus();
      checkAll("t6_prio", 4, 4, 1, 0, 0);
      motion = 1'b0; door_open = 1'b0;
      applyStimulus();
      applyStimulus();
      checkOutput("t6_cnt2", int'(countdown), 2);
      reset = 1'b0; arm_req = 1'b1;
      @(posedge clk);
      #1;
      checkAll("t6_reset", 0, 0, 0, 0, 0);
      checkOutput("t6_reset.arm_fault", int'(arm_fault), 0);
      @(posedge clk);
      #1;
      checkAll("t6_reset_arm", 0, 0, 0, 0, 0);
      reset = 1'b1; arm_req = 1'b0;
      applyStimulus();
      checkAll("t6_after", 0, 0, 0, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
